// File: rtl/sqrt_job_sequencer.sv
// Job sequencer for the 6-bit iterative square-root engine: buffers operands in a small
// FIFO, runs one engine job at a time with a settle window and watchdog, returns results.
module sqrt_job_sequencer #(
  parameter int DATA_W  = 6,
  parameter int RES_W   = 3,
  parameter int DEPTH   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      sq_data_in,
  output logic                   sq_start,
  input  logic [RES_W-1:0]       sq_result,
  input  logic                   sq_done,
  output logic [DATA_W-1:0]      out_operand,
  output logic [RES_W-1:0]       out_root,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + SETTLE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD_OUT  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic              push_s, pop_s, done_s, capture_s, drop_s;
  logic [DATA_W-1:0] cur_op_r, out_operand_r;
  logic [RES_W-1:0]  out_root_r;
  logic              sq_start_r, out_valid_r, busy_r, timeout_err_r;

  assign in_ready    = !reset && (count_r < FULL_CNT);
  assign push_s      = in_valid && in_ready;
  // A floating or unknown done line must never be taken as completion.
  assign done_s      = (sq_done === 1'b1);
  assign fifo_count  = count_r;
  assign sq_data_in  = cur_op_r;
  assign sq_start    = sq_start_r;
  assign out_operand = out_operand_r;
  assign out_root    = out_root_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

  // Job FSM next-state, timer and pop/capture/drop strobes
  always_comb begin
    state_s   = state_r;
    tmr_s     = tmr_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != '0) begin
          pop_s   = 1'b1;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_SETTLE;
        tmr_s   = '0;
      end
      ST_SETTLE: begin
        if (tmr_r == SETTLE_LAST) begin
          state_s = ST_WAIT_DONE;
          tmr_s   = '0;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_s) begin
          capture_s = 1'b1;
          state_s   = ST_HOLD_OUT;
        end else if (tmr_r == TIMEOUT_LAST) begin
          drop_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      ST_HOLD_OUT: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // State, pointers and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      tmr_r         <= '0;
      count_r       <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      cur_op_r      <= '0;
      sq_start_r    <= 1'b0;
      out_operand_r <= '0;
      out_root_r    <= '0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      tmr_r       <= tmr_s;
      count_r     <= count_s;
      sq_start_r  <= (state_s == ST_ISSUE);
      out_valid_r <= (state_s == ST_HOLD_OUT);
      busy_r      <= (state_s != ST_IDLE) || (count_s != '0);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      // The popped operand stays on sq_data_in until the next job is popped.
      if (pop_s) begin
        cur_op_r <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (capture_s) begin
        out_operand_r <= cur_op_r;
        out_root_r    <= sq_result;
      end
      if (drop_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Self-checking bench for sqrt_job_sequencer: directed scenarios plus randomized jobs,
// checked by a behavioural engine model and a job-level monitor.
module tb_sqrt_job_sequencer;
  localparam int DEPTH   = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, sq_done = 1'b0;
  logic [5:0] in_data = 6'd0;
  logic [2:0] sq_result = 3'd0;
  logic       in_ready, sq_start, out_valid, busy, timeout_err;
  logic [5:0] sq_data_in, out_operand;
  logic [2:0] out_root, fifo_count;

  int checks = 0, errors = 0;
  int cyc = 0;
  int mode = 0, fix_lat = 9, rand_lat = 0;
  int eng_op = 0, eng_cnt = 0, eng_lat = 100000;
  logic [5:0] acc_q[$];
  int cur_op = 0, start_cyc = 0, exp_rise = 0, xfer_cyc = -100;
  int job_open = 0, n_start = 0, n_out = 0, last_op = -1, last_root = -1, peak = 0;
  logic prev_valid = 1'b0, prev_xfer = 1'b0, prev_start = 1'b0, prev_to = 1'b0;
  logic [5:0] prev_op = 6'd0;
  logic [2:0] prev_root = 3'd0;
  int s0, o0;

  sqrt_job_sequencer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sq_data_in(sq_data_in), .sq_start(sq_start), .sq_result(sq_result), .sq_done(sq_done),
    .out_operand(out_operand), .out_root(out_root), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [5:0] v);
    int k = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      k++;
      if (k > 200) begin
        chk("push_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    forever begin
      @(negedge clk);
      if (acc_q.size() == 0 && job_open == 0 && busy === 1'b0 && out_valid === 1'b0) break;
      k++;
      if (k > 400) begin
        chk(tag, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Engine model: level done after a latency, or always high, or never
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sq_start === 1'b1) begin
        eng_op  = int'(sq_data_in);
        eng_cnt = 0;
        eng_lat = (rand_lat != 0) ? int'($urandom_range(1, 12)) : fix_lat;
      end else if (eng_cnt < 100000) begin
        eng_cnt++;
      end
      if (mode == 1) begin
        sq_done   = 1'b1;
        sq_result = 3'(isqrt(int'(sq_data_in)));
      end else if (mode == 2 || eng_cnt < eng_lat) begin
        sq_done   = 1'b0;
        sq_result = 3'($urandom);
      end else begin
        sq_done   = 1'b1;
        sq_result = 3'(isqrt(eng_op));
      end
    end
  end

  // Job-level monitor: ordering, latency, one job in flight, stable output, stickiness
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
      job_open   = 0;
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
      prev_start = 1'b0;
      prev_to    = 1'b0;
    end else begin
      if (in_valid === 1'b1 && in_ready === 1'b1) acc_q.push_back(in_data);
      if (sq_start === 1'b1) begin
        chk("start_single_cycle", prev_start, 1'b0);
        chk("start_while_job_open", job_open, 0);
        chk("start_gap_after_xfer", (cyc >= xfer_cyc + 2), 1'b1);
        chk("start_has_job", (acc_q.size() > 0), 1'b1);
        cur_op = (acc_q.size() > 0) ? int'(acc_q.pop_front()) : -1;
        chk("start_data", sq_data_in, cur_op);
        job_open  = 1;
        start_cyc = cyc;
        n_start++;
        if (mode == 1) exp_rise = cyc + SETTLE + 2;
        else if (mode == 2) exp_rise = -1;
        else exp_rise = cyc + imax(eng_lat, SETTLE + 1) + 1;
      end
      if (timeout_err === 1'b1 && !prev_to) begin
        chk("timeout_cycle", cyc, start_cyc + SETTLE + TIMEOUT + 1);
        chk("timeout_job_open", job_open, 1);
        job_open = 0;
      end
      if (prev_to) chk("timeout_sticky", timeout_err, 1'b1);
      if (out_valid === 1'b1 && !prev_valid) begin
        chk("valid_rise_cycle", cyc, exp_rise);
        chk("valid_job_open", job_open, 1);
        chk("out_operand", out_operand, cur_op);
        chk("out_root", out_root, isqrt(cur_op));
      end
      if (prev_valid && !prev_xfer) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_operand", out_operand, prev_op);
        chk("hold_root", out_root, prev_root);
      end
      if (prev_xfer) chk("valid_drop_after_xfer", out_valid, 1'b0);
      chk("count_le_depth", (fifo_count <= 3'(DEPTH)), 1'b1);
      chk("in_ready_vs_count", in_ready, (fifo_count < 3'(DEPTH)));
      chk("busy", busy, (fifo_count != 3'd0) || (job_open != 0));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        last_op   = int'(out_operand);
        last_root = int'(out_root);
        job_open  = 0;
        xfer_cyc  = cyc;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      prev_valid = out_valid;
      prev_xfer  = out_valid && out_ready;
      prev_op    = out_operand;
      prev_root  = out_root;
      prev_start = sq_start;
      prev_to    = timeout_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state
    step(2);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_sq_start", sq_start, 1'b0);
    chk("rst_sq_data_in", sq_data_in, 6'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_operand", out_operand, 6'd0);
    chk("rst_out_root", out_root, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single job 49 -> 7, engine latency 9
    out_ready = 1'b1; mode = 0; fix_lat = 9;
    s0 = n_start; o0 = n_out;
    push(6'd49);
    wait_idle("t1_idle_timeout");
    chk("t1_starts", n_start - s0, 1);
    chk("t1_outputs", n_out - o0, 1);
    chk("t1_last_op", last_op, 49);
    chk("t1_last_root", last_root, 7);

    // Back-to-back pushes keep order
    s0 = n_start; o0 = n_out; peak = 0;
    push(6'd0); push(6'd15); push(6'd63); push(6'd36);
    wait_idle("t2_idle_timeout");
    chk("t2_starts", n_start - s0, 4);
    chk("t2_outputs", n_out - o0, 4);
    chk("t2_peak_count", peak, 3);
    chk("t2_last_op", last_op, 36);
    chk("t2_last_root", last_root, 6);

    // Done held high throughout: ignored until the first wait cycle
    mode = 1;
    step(2);
    s0 = n_start; o0 = n_out;
    push(6'd44); push(6'd8);
    wait_idle("t3_idle_timeout");
    chk("t3_starts", n_start - s0, 2);
    chk("t3_outputs", n_out - o0, 2);
    chk("t3_last_root", last_root, 2);

    // Downstream stall: output holds, FIFO fills, extra push rejected
    mode = 0; fix_lat = 5; out_ready = 1'b0;
    s0 = n_start; o0 = n_out;
    push(6'd9);
    begin
      int k = 0;
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1) break;
        k++;
        if (k > 60) begin chk("t4_valid_timeout", 32'd0, 32'd1); break; end
      end
    end
    @(posedge clk); #1;
    push(6'd16); push(6'd25); push(6'd48); push(6'd62);
    @(negedge clk);
    chk("t4_full_count", fifo_count, 3'd4);
    chk("t4_full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 6'd33;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_reject_in_ready", in_ready, 1'b0);
      chk("t4_reject_count", fifo_count, 3'd4);
      chk("t4_stall_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_single_start_in_stall", n_start - s0, 1);
    out_ready = 1'b1;
    wait_idle("t4_idle_timeout");
    chk("t4_starts", n_start - s0, 5);
    chk("t4_outputs", n_out - o0, 5);
    chk("t4_last_op", last_op, 62);
    chk("t4_last_root", last_root, 7);

    // Hung engine: job dropped by watchdog, next job still runs
    mode = 2;
    s0 = n_start; o0 = n_out;
    push(6'd30); push(6'd50);
    begin
      int k = 0;
      forever begin
        @(negedge clk);
        if (timeout_err === 1'b1) break;
        k++;
        if (k > 80) begin chk("t5_timeout_wait", 32'd0, 32'd1); break; end
      end
    end
    mode = 0; fix_lat = 4;
    @(posedge clk); #1;
    wait_idle("t5_idle_timeout");
    chk("t5_starts", n_start - s0, 2);
    chk("t5_outputs", n_out - o0, 1);
    chk("t5_last_op", last_op, 50);
    chk("t5_last_root", last_root, 7);
    chk("t5_timeout_err", timeout_err, 1'b1);

    // Randomized jobs with random latency and random downstream backpressure
    rand_lat = 1;
    s0 = n_start; o0 = n_out;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          step($urandom_range(0, 5));
          push(6'($urandom_range(0, 63)));
        end
      end
      begin
        repeat (250) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1; rand_lat = 0;
    wait_idle("rand_idle_timeout");
    chk("rand_starts", n_start - s0, 12);
    chk("rand_outputs", n_out - o0, 12);
    chk("rand_timeout_still_set", timeout_err, 1'b1);

    // Reset in the middle of a job with three queued
    fix_lat = 15;
    o0 = n_out;
    push(6'd10); push(6'd20); push(6'd40); push(6'd60);
    step(3);
    @(negedge clk);
    chk("t6_queued", fifo_count, 3'd3);
    chk("t6_no_output_yet", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_in_reset", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_fifo_count", fifo_count, 3'd0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_sq_start", sq_start, 1'b0);
    chk("t6_timeout_err", timeout_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    @(posedge clk); #1;
    fix_lat = 6;
    push(6'd25);
    wait_idle("t6_idle_timeout");
    chk("t6_outputs", n_out - o0, 1);
    chk("t6_last_op", last_op, 25);
    chk("t6_last_root", last_root, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
